// File: rtl/maxpool_output_packer_pkg.sv
// Shared constants and the half-beat entry type for the maxpool output packer.
// The entry type fixes its data width to the package defaults (H_DEF words).
package maxpool_output_packer_pkg;

  localparam int UNITS_DEF      = 8;
  localparam int GROUPS_DEF     = 2;
  localparam int WORD_WIDTH_DEF = 8;
  localparam int H_DEF          = GROUPS_DEF * UNITS_DEF;
  localparam int HALF_W         = H_DEF * WORD_WIDTH_DEF;

  typedef struct packed {
    logic              last;
    logic [HALF_W-1:0] data;
  } half_entry_t;

endpackage

// File: rtl/maxpool_output_packer_fifo.sv
// packer_half_fifo: DEPTH half-beat entries, two-entry write port, one read port.
// Empty reads return zero so downstream outputs sit at 0 after reset.
module packer_half_fifo
  import maxpool_output_packer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_wr0,
  input  logic          i_wr1,
  input  half_entry_t   i_entry0,
  input  half_entry_t   i_entry1,
  input  logic          i_rd,
  output half_entry_t   o_entry,
  output logic [CW-1:0] o_count
);

  half_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wptr1;
  logic [1:0]    w_nwr;

  assign w_wptr1 = r_wptr + 1'b1;
  assign w_nwr   = {1'b0, i_wr0} + {1'b0, i_wr1};

  // i_wr1 is only ever asserted together with i_wr0
  always_ff @(posedge clk) begin
    if (i_wr0) r_mem[r_wptr]  <= i_entry0;
    if (i_wr1) r_mem[w_wptr1] <= i_entry1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nwr);
      r_rptr  <= r_rptr + AW'(i_rd);
      r_count <= r_count + CW'(w_nwr) - CW'(i_rd);
    end
  end

  assign o_entry = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/maxpool_output_packer.sv
// Splits two-copy maxpool beats into dense half-beat entries and streams them out.
// Optional sticky overflow flag: define MAXPOOL_PACKER_OVERFLOW_FLAG_EN.
module maxpool_output_packer
  import maxpool_output_packer_pkg::*;
#(
  parameter  int UNITS      = UNITS_DEF,
  parameter  int GROUPS     = GROUPS_DEF,
  parameter  int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter  int DEPTH      = 8,
  localparam int H          = GROUPS * UNITS,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clken,
  input  logic                      s_valid,
  input  logic [2*H*WORD_WIDTH-1:0] s_data_flat_cgu,
  input  logic [2*H-1:0]            s_keep_flat_cgu,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [H*WORD_WIDTH-1:0]   m_data,
  output logic                      m_last,
  output logic                      overflow
);

  half_entry_t   w_entry0;
  half_entry_t   w_entry1;
  half_entry_t   w_rd_entry;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_need;
  logic          w_full;
  logic          w_take;
  logic          w_fit;
  logic          w_wr0;
  logic          w_wr1;
  logic          w_rd;
  logic          w_unused_keep_lo;

  // A partially kept high half is treated as absent
  assign w_full           = &s_keep_flat_cgu[2*H-1:H];
  assign w_unused_keep_lo = ^s_keep_flat_cgu[H-1:0];

  // Free space is judged on the pre-read count: a same-cycle read never makes room
  assign w_free  = CW'(DEPTH) - w_count;
  assign w_need  = w_full ? CW'(2) : CW'(1);
  assign w_take  = s_valid & clken;
  assign w_fit   = (w_free >= w_need);
  assign w_wr0   = w_take & w_fit;
  assign w_wr1   = w_wr0 & w_full;
  assign w_rd    = m_valid & m_ready & clken;

  assign w_entry0.data = s_data_flat_cgu[H*WORD_WIDTH-1:0];
  assign w_entry0.last = s_last & ~w_full;
  assign w_entry1.data = s_data_flat_cgu[2*H*WORD_WIDTH-1:H*WORD_WIDTH];
  assign w_entry1.last = s_last;

  packer_half_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .i_wr0    (w_wr0),
    .i_wr1    (w_wr1),
    .i_entry0 (w_entry0),
    .i_entry1 (w_entry1),
    .i_rd     (w_rd),
    .o_entry  (w_rd_entry),
    .o_count  (w_count)
  );

  assign s_ready = (w_free >= CW'(2));
  assign m_valid = (w_count != '0);
  assign m_data  = w_rd_entry.data;
  assign m_last  = w_rd_entry.last;

`ifdef MAXPOOL_PACKER_OVERFLOW_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              r_overflow <= 1'b0;
    else if (w_take & ~w_fit) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_maxpool_output_packer.sv
// Directed bench for maxpool_output_packer at default parameters (H=16, DEPTH=8).
// Overflow expectation follows MAXPOOL_PACKER_OVERFLOW_FLAG_EN.
module tb_maxpool_output_packer;

`ifdef MAXPOOL_PACKER_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         clken;
  logic         s_valid;
  logic [255:0] s_data;
  logic [31:0]  s_keep;
  logic         s_last;
  logic         s_ready;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         overflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxpool_output_packer dut (
    .clk             (clk),
    .resetn          (resetn),
    .clken           (clken),
    .s_valid         (s_valid),
    .s_data_flat_cgu (s_data),
    .s_keep_flat_cgu (s_keep),
    .s_last          (s_last),
    .s_ready         (s_ready),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .overflow        (overflow)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // word i of beat 'seed' is seed*32+i, so every word of every beat is distinct
  function automatic logic [255:0] beat(input int seed);
    logic [255:0] b;
    for (int i = 0; i < 32; i++) b[i*8 +: 8] = 8'(seed * 32 + i);
    return b;
  endfunction

  function automatic logic [127:0] lo(input int seed);
    logic [255:0] b;
    b = beat(seed);
    return b[127:0];
  endfunction

  function automatic logic [127:0] hi(input int seed);
    logic [255:0] b;
    b = beat(seed);
    return b[255:128];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int seed, input logic [15:0] keep_hi, input logic last);
    s_valid = 1'b1;
    s_data  = beat(seed);
    s_keep  = {keep_hi, 16'hFFFF};
    s_last  = last;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [127:0] exp_d, input logic exp_l);
    chk({tag, "_valid"}, m_valid, 1'b1);
    chk({tag, "_data"}, m_data, exp_d);
    chk({tag, "_last"}, m_last, exp_l);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    resetn  = 1'b0;
    clken   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #12;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // two full beats back to back, continuous drain
    m_ready = 1'b1;
    send(1, 16'hFFFF, 1'b0);
    chk("ab_c1_data", m_data, lo(1));
    chk("ab_c1_last", m_last, 1'b0);
    send(2, 16'hFFFF, 1'b1);
    chk("ab_c2_data", m_data, hi(1));
    chk("ab_c2_last", m_last, 1'b0);
    tick();
    chk("ab_c3_data", m_data, lo(2));
    chk("ab_c3_last", m_last, 1'b0);
    tick();
    chk("ab_c4_data", m_data, hi(2));
    chk("ab_c4_last", m_last, 1'b1);
    tick();
    chk("ab_c5_valid", m_valid, 1'b0);

    // half beat ends a packet
    send(3, 16'h0000, 1'b1);
    chk("half_data", m_data, lo(3));
    chk("half_last", m_last, 1'b1);
    tick();
    chk("half_done", m_valid, 1'b0);
    m_ready = 1'b0;

    // fill to DEPTH with no drain; fifth beat is dropped
    for (int b = 1; b <= 5; b++) begin
      send(b, 16'hFFFF, 1'b0);
      if (b == 2) chk("fill_s_ready_2", s_ready, 1'b1);
      if (b == 4) chk("fill_s_ready_4", s_ready, 1'b0);
    end
    chk("fill_overflow", overflow, OVF_EXP);
    for (int k = 0; k < 8; k++)
      drain_one("fill_drain", (k % 2 == 0) ? lo(k / 2 + 1) : hi(k / 2 + 1), 1'b0);
    chk("fill_empty", m_valid, 1'b0);

    // asynchronous reset in the middle of a packet with 3 entries held
    send(6, 16'hFFFF, 1'b0);
    send(7, 16'h0000, 1'b0);
    chk("mid_valid_pre", m_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_overflow", overflow, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_data", m_data, '0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    send(2, 16'h0000, 1'b1);
    drain_one("post_rst", lo(2), 1'b1);
    chk("post_rst_empty", m_valid, 1'b0);

    // count=7: simultaneous read and partial-keep half-beat write
    send(1, 16'hFFFF, 1'b0);
    send(2, 16'hFFFF, 1'b0);
    send(3, 16'hFFFF, 1'b0);
    send(4, 16'h0000, 1'b0);
    chk("c7_s_ready", s_ready, 1'b0);
    m_ready = 1'b1;
    send(5, 16'h00FF, 1'b1);
    m_ready = 1'b0;
    chk("c7_overflow", overflow, 1'b0);
    drain_one("c7_e0", hi(1), 1'b0);
    drain_one("c7_e1", lo(2), 1'b0);
    drain_one("c7_e2", hi(2), 1'b0);
    drain_one("c7_e3", lo(3), 1'b0);
    drain_one("c7_e4", hi(3), 1'b0);
    drain_one("c7_e5", lo(4), 1'b0);
    drain_one("c7_e6", lo(5), 1'b1);
    chk("c7_empty", m_valid, 1'b0);

    // clock enable low freezes both ports
    send(3, 16'hFFFF, 1'b1);
    clken   = 1'b0;
    s_valid = 1'b1;
    s_data  = beat(4);
    s_keep  = '1;
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ce_valid", m_valid, 1'b1);
      chk("ce_data", m_data, lo(3));
      chk("ce_last", m_last, 1'b0);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    clken   = 1'b1;
    drain_one("ce_e0", lo(3), 1'b0);
    drain_one("ce_e1", hi(3), 1'b1);
    chk("ce_empty", m_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
